// File: rtl/spi_slave_ctrl_pkg.sv
// Shared definitions for the SPI slave controller and its RAM wrapper:
// FSM encodings, default widths and the two-bit command codes.
package spi_slave_ctrl_pkg;

  localparam int unsigned FRAME_W_DEF = 10;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  // Sub-phase of an active transaction: receiving, awaiting RAM data, shifting out, finished
  typedef enum logic [1:0] {
    PH_RX   = 2'd0,
    PH_WAIT = 2'd1,
    PH_TX   = 2'd2,
    PH_DONE = 2'd3
  } phase_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic next_rd_addr_seen(input logic [1:0] cmd, input logic cur);
    logic nxt;
    case (cmd)
      CMD_RD_ADDR: nxt = 1'b1;
      CMD_RD_DATA: nxt = 1'b0;
      CMD_WR_ADDR: nxt = cur;
      CMD_WR_DATA: nxt = cur;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_ram.sv
// Single-port RAM driven by decoded SPI frames: address/data writes,
// read-address latch and read strobe returning one byte with tx_valid.
module spi_ram
  import spi_slave_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W+1:0] din,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] dout,
  output logic              tx_valid
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_dout;
  logic              r_tx_valid;
  logic [1:0]        w_cmd;
  logic [ADDR_W-1:0] w_payload;

  assign w_cmd     = din[ADDR_W+1:ADDR_W];
  assign w_payload = din[ADDR_W-1:0];
  assign dout      = r_dout;
  assign tx_valid  = r_tx_valid;

  // Storage array carries no reset
  always_ff @(posedge clk) begin
    if (rx_valid && (w_cmd == CMD_WR_DATA)) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  // Address latches and read return path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_addr  <= {ADDR_W{1'b0}};
      r_rd_addr  <= {ADDR_W{1'b0}};
      r_dout     <= {ADDR_W{1'b0}};
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (rx_valid) begin
        case (w_cmd)
          CMD_WR_ADDR: r_wr_addr <= w_payload;
          CMD_WR_DATA: r_wr_addr <= r_wr_addr;
          CMD_RD_ADDR: r_rd_addr <= w_payload;
          CMD_RD_DATA: begin
            r_dout     <= r_mem[r_rd_addr];
            r_tx_valid <= 1'b1;
          end
          default: r_tx_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_ram_top.sv
// SPI-attached RAM: controller front end wired to the single-port RAM.
module spi_ram_top
  import spi_slave_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int unsigned FRAME_W = DATA_W + 2;

  logic [FRAME_W-1:0] w_rx_data;
  logic               w_rx_valid;
  logic [DATA_W-1:0]  w_tx_data;
  logic               w_tx_valid;

  spi_slave_ctrl #(
    .FRAME_W (FRAME_W),
    .DATA_W  (DATA_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (w_rx_data),
    .rx_valid (w_rx_valid),
    .tx_data  (w_tx_data),
    .tx_valid (w_tx_valid)
  );

  spi_ram #(
    .ADDR_W (DATA_W)
  ) u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (w_rx_data),
    .rx_valid (w_rx_valid),
    .dout     (w_tx_data),
    .tx_valid (w_tx_valid)
  );

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises 10-bit command frames for the RAM and
// serialises the returned read byte on MISO after a read-data frame.
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(DATA_W - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  phase_e             r_phase;
  phase_e             w_phase_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic [DATA_W-1:0]  r_tx_shift;
  logic               r_miso;
  logic               r_rd_addr_seen;

  logic [FRAME_W-1:0] w_frame_full;
  logic               w_shift_in;
  logic               w_frame_done;
  logic               w_capture;
  logic               w_tx_step;
  logic               w_abort;

  assign w_frame_full = {r_shift, MOSI};
  assign MISO         = r_miso;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;

  // State and phase registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= PH_RX;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state decode; slave-select release overrides everything else
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_shift_in   = 1'b0;
    w_frame_done = 1'b0;
    w_capture    = 1'b0;
    w_tx_step    = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        w_phase_nxt = PH_RX;
        if (!SS_n) begin
          w_state_nxt = CHK_CMD;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CHK_CMD: begin
        w_shift_in  = 1'b1;
        w_phase_nxt = PH_RX;
        if (!MOSI) begin
          w_state_nxt = WRITE;
        end else if (r_rd_addr_seen) begin
          w_state_nxt = READ_DATA;
        end else begin
          w_state_nxt = READ_ADD;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        case (r_phase)
          PH_RX: begin
            w_shift_in = 1'b1;
            if (r_cnt == RX_LAST) begin
              w_frame_done = 1'b1;
              w_phase_nxt  = (r_state == READ_DATA) ? PH_WAIT : PH_DONE;
            end else begin
              w_phase_nxt = PH_RX;
            end
          end
          PH_WAIT: begin
            if (tx_valid) begin
              w_capture   = 1'b1;
              w_phase_nxt = PH_TX;
            end else begin
              w_phase_nxt = PH_WAIT;
            end
          end
          PH_TX: begin
            w_tx_step = 1'b1;
            if (r_cnt == TX_LAST) begin
              w_phase_nxt = PH_DONE;
            end else begin
              w_phase_nxt = PH_TX;
            end
          end
          PH_DONE: w_phase_nxt = PH_DONE;
          default: w_phase_nxt = PH_DONE;
        endcase
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = PH_RX;
      end
    endcase
    if (SS_n && (r_state != IDLE)) begin
      w_abort      = 1'b1;
      w_state_nxt  = IDLE;
      w_phase_nxt  = PH_RX;
      w_shift_in   = 1'b0;
      w_frame_done = 1'b0;
      w_capture    = 1'b0;
      w_tx_step    = 1'b0;
    end else begin
      w_abort = 1'b0;
    end
  end

  // Frame shifter, bit counter, frame output and MISO serializer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= CNT_ZERO;
      r_shift        <= {(FRAME_W-1){1'b0}};
      r_rx_data      <= {FRAME_W{1'b0}};
      r_rx_valid     <= 1'b0;
      r_tx_shift     <= {DATA_W{1'b0}};
      r_miso         <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_cnt      <= CNT_ZERO;
        r_tx_shift <= {DATA_W{1'b0}};
        r_miso     <= 1'b0;
      end else if (w_shift_in) begin
        r_shift <= w_frame_full[FRAME_W-2:0];
        if (w_frame_done) begin
          r_cnt          <= CNT_ZERO;
          r_rx_data      <= w_frame_full;
          r_rx_valid     <= 1'b1;
          r_rd_addr_seen <= next_rd_addr_seen(w_frame_full[FRAME_W-1 -: 2], r_rd_addr_seen);
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else if (w_capture) begin
        // MSB goes straight out so it appears the cycle after capture
        r_miso     <= tx_data[DATA_W-1];
        r_tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
        r_cnt      <= CNT_ZERO;
      end else if (w_tx_step) begin
        if (r_cnt == TX_LAST) begin
          r_miso     <= 1'b0;
          r_tx_shift <= {DATA_W{1'b0}};
          r_cnt      <= CNT_ZERO;
        end else begin
          r_miso     <= r_tx_shift[DATA_W-1];
          r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          r_cnt      <= r_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl; a RAM-backed top shares the SPI pins
// so the write-then-read sequence is also checked end to end.
module tb_spi_slave_ctrl;
  import spi_slave_ctrl_pkg::*;

  localparam int FW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic          top_miso;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.FRAME_W(FW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  spi_ram_top #(.DATA_W(DW)) u_top (
    .clk   (clk),
    .rst_n (rst_n),
    .SS_n  (SS_n),
    .MOSI  (MOSI),
    .MISO  (top_miso)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge with SS_n high; returns one cycle after rx_valid, SS_n still low
  task automatic send_frame(input logic [FW-1:0] f, input string tag);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);
    for (int i = FW - 1; i >= 0; i--) begin
      MOSI = f[i];
      @(negedge clk);
      if (i == 5) chk({tag, "_miso_rx"}, 32'(MISO), 32'd0);
      if (i == 1) chk({tag, "_pre"}, 32'(rx_valid), 32'd0);
    end
    chk({tag, "_vld"}, 32'(rx_valid), 32'd1);
    chk({tag, "_dat"}, 32'(rx_data), 32'(f));
    MOSI = 1'b1;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rx_valid), 32'd0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
  endtask

  // Expects capture to happen at the edge before this call's first sample
  task automatic chk_shift(input logic [DW-1:0] exp, input string tag, input logic with_top);
    for (int i = DW - 1; i >= 0; i--) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(MISO), 32'(exp[i]));
      if (with_top) chk($sformatf("%s_top_b%0d", tag, i), 32'(top_miso), 32'(exp[i]));
      @(negedge clk);
    end
    chk({tag, "_end"}, 32'(MISO), 32'd0);
    if (with_top) chk({tag, "_top_end"}, 32'(top_miso), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(rx_valid), 32'd0);
    chk("rst_dat", 32'(rx_data), 32'd0);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_top_miso", 32'(top_miso), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Writes: address 3C then data A5; trailing MOSI after the frame is ignored
    send_frame(10'h03C, "wr_addr");
    repeat (2) @(negedge clk);
    chk("wr_addr_trail_vld", 32'(rx_valid), 32'd0);
    chk("wr_addr_trail_dat", 32'(rx_data), 32'h03C);
    end_frame();
    send_frame(10'h1A5, "wr_data");
    end_frame();

    // Stray tx_valid in IDLE and WRITE
    tx_valid = 1'b1; tx_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stray_idle%0d", k), 32'(MISO), 32'd0);
    end
    send_frame(10'h03C, "stray_wr");
    chk("stray_wr_after", 32'(MISO), 32'd0);
    end_frame();
    chk("stray_idle_end", 32'(MISO), 32'd0);
    tx_valid = 1'b0;

    // Read: address 3C, then read-data frame; RAM returns A5
    send_frame(10'h23C, "rd_addr");
    end_frame();
    send_frame(10'h300, "rd_data");
    chk("rd_wait_miso", 32'(MISO), 32'd0);
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_data = 8'h3C;
    for (int i = DW - 1; i >= 0; i--) begin
      chk($sformatf("rd_b%0d", i), 32'(MISO), 32'(tx_pat_a5(i)));
      chk($sformatf("rd_top_b%0d", i), 32'(top_miso), 32'(tx_pat_a5(i)));
      if (i == 6) tx_valid = 1'b0;
      @(negedge clk);
    end
    chk("rd_end", 32'(MISO), 32'd0);
    chk("rd_top_end", 32'(top_miso), 32'd0);
    @(negedge clk);
    chk("rd_end2", 32'(MISO), 32'd0);
    end_frame();

    // Routing: without a preceding 10 frame, 1-led frames go to READ_ADD
    for (int r = 0; r < 2; r++) begin
      send_frame(10'h300, $sformatf("route%0d", r));
      tx_valid = 1'b1; tx_data = 8'hFF;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("route%0d_miso%0d", r, k), 32'(MISO), 32'd0);
      end
      tx_valid = 1'b0;
      end_frame();
    end
    send_frame(10'h2C3, "route_ra");
    end_frame();
    send_frame(10'h300, "route_rd");
    tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge clk);
    tx_valid = 1'b0;
    chk_shift(8'h5A, "route_sh", 1'b0);
    end_frame();

    // Abort after 5 bits of 00,3C
    SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk);
    for (int i = 9; i >= 5; i--) begin
      MOSI = frame_03c(i);
      @(negedge clk);
    end
    SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk("abort_vld", 32'(rx_valid), 32'd0);
    @(negedge clk);
    chk("abort_vld2", 32'(rx_valid), 32'd0);
    chk("abort_dat_hold", 32'(rx_data), 32'h300);
    send_frame(10'h1A5, "abort_next");
    end_frame();

    // SS_n rises in the slot of the last frame bit
    SS_n = 1'b0; MOSI = 1'b0;
    @(negedge clk);
    for (int i = 9; i >= 1; i--) begin
      MOSI = frame_0c3(i);
      @(negedge clk);
    end
    SS_n = 1'b1; MOSI = 1'b1;
    @(negedge clk);
    chk("lastbit_vld", 32'(rx_valid), 32'd0);
    MOSI = 1'b0;
    @(negedge clk);
    chk("lastbit_vld2", 32'(rx_valid), 32'd0);
    chk("lastbit_dat_hold", 32'(rx_data), 32'h1A5);

    // Reset during shift-out after three MISO bits
    send_frame(10'h23C, "rst_ra");
    end_frame();
    send_frame(10'h300, "rst_rd");
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("rst_sh_b7", 32'(MISO), 32'd1);
    @(negedge clk);
    chk("rst_sh_b6", 32'(MISO), 32'd0);
    @(negedge clk);
    chk("rst_sh_b5", 32'(MISO), 32'd1);
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    chk("rst_mid_miso", 32'(MISO), 32'd0);
    chk("rst_mid_seen", 32'(dut.r_rd_addr_seen), 32'd0);
    chk("rst_mid_vld", 32'(rx_valid), 32'd0);
    chk("rst_mid_dat", 32'(rx_data), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet%0d", k), 32'(MISO), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_quiet", 32'(MISO), 32'd0);
    send_frame(10'h0C3, "post_rst");
    end_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  function automatic logic tx_pat_a5(input int idx);
    logic [7:0] v;
    v = 8'hA5;
    return v[idx];
  endfunction

  function automatic logic frame_03c(input int idx);
    logic [9:0] v;
    v = 10'h03C;
    return v[idx];
  endfunction

  function automatic logic frame_0c3(input int idx);
    logic [9:0] v;
    v = 10'h0C3;
    return v[idx];
  endfunction

endmodule
